// File: rtl/cycle_finisher.sv
// Cycle counter with a run/drain/done sequence and an optional event FIFO of counted cycles.
// Event path enabled by defining CYCLE_FINISHER_EVT_EN; otherwise RUN finishes straight into DONE.
module cycle_finisher #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cyc,
    output logic             busy,
    output logic             done,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_cyc,
    output logic             evt_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    state_t           run_exit_state;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             accept_start;
    logic             advance;
    logic             last_cyc;
    logic             drain_exit;

    assign accept_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign advance      = (state_q == S_RUN) && !pause;
    assign last_cyc     = (cyc_q == limit_q);

`ifdef CYCLE_FINISHER_EVT_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             pop;
    logic             do_push;

    assign full      = (count_q == DEPTH_C);
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign do_push   = advance && (!full || pop);
    assign evt_cyc   = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_ovf   = ovf_q;

    assign run_exit_state = S_DRAIN;
    assign drain_exit     = (count_q == '0) || (pop && !do_push && count_q == (AW+1)'(1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept_start) begin
            ovf_d = 1'b0;
        end else if (advance && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: an empty count hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= cyc_q;
        end
    end
`else
    logic unused_evt_ready;

    assign unused_evt_ready = evt_ready;
    assign evt_valid        = 1'b0;
    assign evt_cyc          = '0;
    assign evt_ovf          = 1'b0;
    assign run_exit_state   = S_DONE;
    assign drain_exit       = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        limit_d = limit_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_start) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    limit_d = limit;
                end
            end
            S_RUN: begin
                if (advance) begin
                    if (last_cyc) begin
                        state_d = run_exit_state;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_exit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            limit_q <= limit_d;
        end
    end

    assign cyc  = cyc_q;
    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: doc/cycle_finisher.md
CYCLE_FINISHER -- requirements
Module: cycle_finisher

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of cycle counter and limit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begin a counting run.
REQ-006 SHALL have port pause, input, 1 bit: hold counter in RUN.
REQ-007 SHALL have port limit, input, CNT_W bits: final cycle index; sampled on accepted start.
REQ-008 SHALL have port cyc, output, CNT_W bits: current cycle count.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-010 SHALL have port done, output, 1 bit: high in DONE; drives the bench finish request.
REQ-011 SHALL have port evt_valid, output, 1 bit: FIFO head valid.
REQ-012 SHALL have port evt_ready, input, 1 bit: consumer accepts head.
REQ-013 SHALL have port evt_cyc, output, CNT_W bits: cycle index of head event.
REQ-014 SHALL have port evt_ovf, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, registered.
REQ-016 IDLE: start=1 SHALL go to RUN next cycle, clear cyc to 0, clear evt_ovf, latch limit into limit_q.
REQ-017 RUN, pause=0: SHALL push the current cyc into the FIFO and increment cyc by 1 at the next edge (non-blocking semantics).
REQ-018 RUN, pause=1: cyc, FIFO push and state SHALL hold.
REQ-019 RUN, pause=0 and cyc==limit_q: SHALL push that final event and go to DRAIN, with cyc frozen at limit_q.
REQ-020 limit=0 SHALL finish after exactly one counted RUN cycle; event 0 is pushed.
REQ-021 DRAIN: SHALL go to DONE on the cycle the FIFO becomes empty, i.e. the pop of the last entry.
REQ-022 DONE: done=1 and cyc holds. start=1 SHALL re-enter RUN with the REQ-016 actions.
REQ-023 start SHALL be ignored in RUN and DRAIN.
REQ-024 FIFO handshake: a pop SHALL occur when evt_valid && evt_ready; evt_cyc SHALL be stable while evt_valid && !evt_ready.
REQ-025 Full FIFO with push and pop in the same cycle: both SHALL occur, with no drop.
REQ-026 Full FIFO with push and no pop: the push SHALL be dropped and evt_ovf set until the next accepted start or reset.
REQ-027 Empty FIFO with push: evt_valid SHALL rise the next cycle; there is no fall-through.
REQ-028 cyc arithmetic SHALL be modulo 2^CNT_W. Wrap is unreachable because the run ends at limit_q ≤ 2^CNT_W−1.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, cyc=0, busy=0, done=0, evt_valid=0, evt_cyc=0, evt_ovf=0, FIFO empty, limit_q=0.
REQ-030 Reset mid-RUN or mid-DRAIN SHALL discard all FIFO contents; no event is emitted after release.
REQ-031 Release of rst SHALL require a start before any counting.

Configuration
REQ-032 Macro CYCLE_FINISHER_EVT_EN defined: the FIFO and event ports SHALL be functional as above.
REQ-033 Macro CYCLE_FINISHER_EVT_EN undefined: no FIFO SHALL exist; evt_valid, evt_cyc and evt_ovf SHALL be tied 0; evt_ready SHALL be ignored; RUN SHALL go straight to DONE, skipping DRAIN.

Verification
REQ-034 limit=10, pause=0, evt_ready=1, EVT_EN: the bench SHALL see events 0..10 in order; done rises 1 cycle after the last pop; cyc=10.
REQ-035 limit=3, pause=1 for 2 cycles after event 1: the bench SHALL see events 0,1,2,3 with no duplicates; done is delayed by exactly 2 cycles.
REQ-036 limit=7, evt_ready=0 throughout, FIFO_DEPTH=4: the bench SHALL see evt_ovf=1 and the FIFO holding 0..3; DRAIN persists. Raising evt_ready SHALL drain 0..3, then DONE.
REQ-037 rst pulsed at cyc=5 of a limit=10 run: all outputs 0 immediately; evt_valid stays 0 after release until start.
REQ-038 limit=0, then start again in DONE with limit=2: the bench SHALL see event 0 and done; then done falls, events 0,1,2 follow, and done returns.
REQ-039 EVT_EN undefined, limit=10: done SHALL rise 11 cycles after the first RUN cycle, with evt_valid constantly 0.
